// File: rtl/net_override_ctrl.sv
// Cycle-scheduled per-bit force/release override stage between a net driver and its consumers.
// Optional feature: define NET_OVR_LATE_CHECK_EN to drop late commands and raise sticky err_late_o.
module net_override_ctrl #(
    parameter int W     = 9,
    parameter int DEPTH = 4,
    parameter int CW    = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [W-1:0]  drv_i,
    input  logic          cmd_valid_i,
    output logic          cmd_ready_o,
    input  logic          cmd_op_i,
    input  logic [W-1:0]  cmd_mask_i,
    input  logic [W-1:0]  cmd_value_i,
    input  logic [CW-1:0] cmd_cycle_i,
    output logic [W-1:0]  net_o,
    output logic [W-1:0]  forced_o,
    output logic [CW-1:0] cyc_o,
    output logic          err_late_o
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {S_EMPTY, S_WAIT, S_APPLY} state_t;

    typedef struct packed {
        logic          op;
        logic [W-1:0]  mask;
        logic [W-1:0]  value;
        logic [CW-1:0] cycle;
    } cmd_t;

    cmd_t          r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [AW:0]   r_count;
    logic [CW-1:0] r_cyc;
    logic [W-1:0]  r_frc_en, r_frc_val;
    state_t        r_state, w_state_nxt;

    cmd_t          w_head;
    logic [CW-1:0] w_next_cycle, w_d_head, w_d_next;
    logic          w_push, w_pop, w_apply, w_more;
`ifdef NET_OVR_LATE_CHECK_EN
    logic          w_drop;
    logic          r_err;
`endif

    assign cmd_ready_o  = (r_count != (AW+1)'(DEPTH));
    assign w_push       = cmd_valid_i & cmd_ready_o;
    assign w_head       = r_mem[r_rd_ptr];
    assign w_next_cycle = r_mem[r_rd_ptr + AW'(1)].cycle;
    // Distance to the scheduled cycle; MSB set means the slot is already in the past.
    assign w_d_head     = w_head.cycle - r_cyc;
    assign w_d_next     = w_next_cycle - r_cyc;
    assign w_more       = (r_count > (AW+1)'(1)) | w_push;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_apply     = 1'b0;
`ifdef NET_OVR_LATE_CHECK_EN
        w_drop      = 1'b0;
`endif
        unique case (r_state)
            S_EMPTY: begin
                if (w_push) w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (w_d_head == '0) begin
                    w_state_nxt = S_APPLY;
                end else if (w_d_head[CW-1]) begin
`ifdef NET_OVR_LATE_CHECK_EN
                    w_pop       = 1'b1;
                    w_drop      = 1'b1;
                    w_state_nxt = w_more ? S_WAIT : S_EMPTY;
`else
                    w_state_nxt = S_APPLY;
`endif
                end
            end
            S_APPLY: begin
                w_pop   = 1'b1;
                w_apply = 1'b1;
                // Back-to-back commands already due keep applying one per cycle.
                if ((r_count > (AW+1)'(1)) && ((w_d_next == '0) || w_d_next[CW-1]))
                    w_state_nxt = S_APPLY;
                else if (w_more)
                    w_state_nxt = S_WAIT;
                else
                    w_state_nxt = S_EMPTY;
            end
            default: w_state_nxt = S_EMPTY;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_EMPTY;
            r_cyc     <= '0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_frc_en  <= '0;
            r_frc_val <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cyc   <= r_cyc + CW'(1);
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
            if (w_apply) begin
                if (!w_head.op) begin
                    r_frc_en  <= r_frc_en | w_head.mask;
                    r_frc_val <= (r_frc_val & ~w_head.mask) | (w_head.value & w_head.mask);
                end else begin
                    r_frc_en  <= r_frc_en & ~w_head.mask;
                end
            end
        end
    end

    // NOTE: the command storage is deliberately not reset; pointers and count decide validity.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= {cmd_op_i, cmd_mask_i, cmd_value_i, cmd_cycle_i};
    end

`ifdef NET_OVR_LATE_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      r_err <= 1'b0;
        else if (w_drop) r_err <= 1'b1;
    end
    assign err_late_o = r_err;
`else
    assign err_late_o = 1'b0;
`endif

    assign net_o    = (r_frc_en & r_frc_val) | (~r_frc_en & drv_i);
    assign forced_o = r_frc_en;
    assign cyc_o    = r_cyc;

endmodule

// File: tb/tb_net_override_ctrl.sv
// Randomized bench for net_override_ctrl against a schedule-level model of when each command lands.
module tb_net_override_ctrl;
    localparam int W = 9, DEPTH = 4, CW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [W-1:0]  drv_i;
    logic          cmd_valid_i, cmd_op_i;
    logic          cmd_ready_o, err_late_o;
    logic [W-1:0]  cmd_mask_i, cmd_value_i, net_o, forced_o;
    logic [CW-1:0] cmd_cycle_i, cyc_o;

    always #5 clk = ~clk;

    net_override_ctrl #(.W(W), .DEPTH(DEPTH), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .drv_i(drv_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_op_i(cmd_op_i),
        .cmd_mask_i(cmd_mask_i), .cmd_value_i(cmd_value_i), .cmd_cycle_i(cmd_cycle_i),
        .net_o(net_o), .forced_o(forced_o), .cyc_o(cyc_o), .err_late_o(err_late_o)
    );

    // Model: each accepted command becomes an event at the cycle its effect/pop becomes visible.
    typedef struct {
        int         vis;
        bit         drop;
        bit         op;
        logic [8:0] mask;
        logic [8:0] val;
    } ev_t;

    ev_t        ev[$];
    logic [8:0] m_en, m_val;
    bit         m_err;
    int         tcyc, last_vis, last_n;
    bit         have_last, last_drop, rand_drv, pin_phase;
    int         n_cmp = 0, n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at cyc %0d", name, act, exp, tcyc);
        end
    endtask

    function automatic bit due_by(input int n, input int ref_c);
        logic [15:0] d;
        d = 16'(n - ref_c);
        return (d == 16'd0) || d[15];
    endfunction

    task automatic model_reset();
        ev.delete();
        m_en = '0; m_val = '0; m_err = 1'b0;
        tcyc = 0; last_vis = 0; last_n = 0; have_last = 1'b0; last_drop = 1'b0;
    endtask

    task automatic model_push(input bit op, input logic [8:0] mask, input logic [8:0] val, input int n);
        ev_t         e;
        int          ws;
        logic [15:0] d;
        e.op = op; e.mask = mask; e.val = val; e.drop = 1'b0;
        if (have_last && !last_drop && last_vis > tcyc + 1 && due_by(n, last_vis - 1)) begin
            e.vis = last_vis + 1;
        end else begin
            ws = (last_vis > tcyc + 1) ? last_vis : tcyc + 1;
            d  = 16'(n - ws);
            if (d[15]) begin
`ifdef NET_OVR_LATE_CHECK_EN
                e.vis = ws + 1; e.drop = 1'b1;
`else
                e.vis = ws + 2;
`endif
            end else begin
                e.vis = ws + int'(d) + 2;
            end
        end
        ev.push_back(e);
        last_vis = e.vis; last_n = n; have_last = 1'b1; last_drop = e.drop;
    endtask

    task automatic model_edge();
        tcyc++;
        while (ev.size() > 0 && ev[0].vis == tcyc) begin
            if (ev[0].drop) m_err = 1'b1;
            else if (!ev[0].op) begin
                m_en  = m_en | ev[0].mask;
                m_val = (m_val & ~ev[0].mask) | (ev[0].val & ev[0].mask);
            end else m_en = m_en & ~ev[0].mask;
            void'(ev.pop_front());
        end
    endtask

    task automatic compare();
        check("net_o", net_o, (m_en & m_val) | (~m_en & drv_i));
        check("forced_o", forced_o, m_en);
        check("cyc_o", cyc_o, 16'(tcyc));
        check("cmd_ready_o", cmd_ready_o, ev.size() < DEPTH);
        check("err_late_o", err_late_o, m_err);
    endtask

    // Hand-computed literals for the directed timeline (drv_i = ~cyc).
    task automatic pins();
        if (!pin_phase) return;
        case (tcyc)
            5: begin
                check("c5_forced", forced_o, 9'h001);
                check("c5_bit0", net_o[0], 1'b0);
                check("c5_hi", net_o[8:1], 8'hFD);
            end
            6:  check("c6_hi", net_o[8:1], 8'h5F);
            8:  check("c8_hi", net_o[8:1], 8'hF5);
            11: begin
                check("c11_forced", forced_o, 9'h000);
                check("c11_net", net_o, 9'h1F4);
            end
            14: check("c14_net", net_o, 9'h0B5);
            15: begin
                check("c15_net", net_o, 9'h14A);
                check("c15_forced", forced_o, 9'h1FF);
            end
            20: check("c20_full", cmd_ready_o, 1'b0);
            51: check("c51_full", cmd_ready_o, 1'b0);
            52: check("c52_ready", cmd_ready_o, 1'b1);
            91: check("c91_err", err_late_o, 1'b0);
            93: begin
`ifdef NET_OVR_LATE_CHECK_EN
                check("c93_err", err_late_o, 1'b1);
                check("c93_net", net_o, 9'h155);
`else
                check("c93_err", err_late_o, 1'b0);
                check("c93_net", net_o, 9'h0AA);
`endif
            end
            default: ;
        endcase
    endtask

    task automatic tick_body(input bit v, input bit op, input logic [8:0] mask,
                             input logic [8:0] val, input int n, output bit acc);
        drv_i       = rand_drv ? 9'($urandom) : ~tcyc[8:0];
        cmd_valid_i = v;
        cmd_op_i    = op;
        cmd_mask_i  = mask;
        cmd_value_i = val;
        cmd_cycle_i = 16'(n);
        #1;
        compare();
        pins();
        acc = v && (ev.size() < DEPTH);
        if (acc) model_push(op, mask, val, n);
        @(posedge clk);
        model_edge();
    endtask

    task automatic tick(input bit v, input bit op, input logic [8:0] mask,
                        input logic [8:0] val, input int n, output bit acc);
        @(negedge clk);
        tick_body(v, op, mask, val, n, acc);
    endtask

    task automatic idle_to(input int c);
        bit acc;
        while (tcyc < c) tick(1'b0, 1'b0, '0, '0, 0, acc);
    endtask

    task automatic push(input bit op, input logic [8:0] mask, input logic [8:0] val, input int n);
        bit acc;
        int tries;
        tries = 0;
        acc   = 1'b0;
        while (!acc && tries < 200) begin
            tick(1'b1, op, mask, val, n, acc);
            tries++;
        end
        if (!acc) begin
            n_cmp++;
            n_bad++;
            $display("FAIL push_timeout: got no accept expected accept within 200 cycles");
        end
    endtask

    task automatic apply_reset();
        bit acc;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_forced", forced_o, 9'h000);
        check("rst_cyc", cyc_o, 16'h0000);
        check("rst_ready", cmd_ready_o, 1'b1);
        check("rst_net", net_o, drv_i);
        check("rst_err", err_late_o, 1'b0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tick_body(1'b0, 1'b0, '0, '0, 0, acc);
    endtask

    initial begin
        bit acc;
        rst_n = 1'b0;
        drv_i = '0; cmd_valid_i = 1'b0; cmd_op_i = 1'b0;
        cmd_mask_i = '0; cmd_value_i = '0; cmd_cycle_i = '0;
        rand_drv = 1'b0;
        pin_phase = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check("init_forced", forced_o, 9'h000);
        check("init_cyc", cyc_o, 16'h0000);
        check("init_ready", cmd_ready_o, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        tick_body(1'b0, 1'b0, '0, '0, 0, acc);

        push(1'b0, 9'h001, 9'h000, 3);
        push(1'b0, 9'h1FE, 9'h0BE, 4);
        push(1'b0, 9'h1FE, 9'h1EA, 6);
        push(1'b1, 9'h1FF, 9'h000, 9);
        push(1'b0, 9'h1FF, 9'h0B5, 12);
        push(1'b0, 9'h1FF, 9'h14A, 12);

        idle_to(16);
        push(1'b0, 9'h1FF, 9'h111, 50);
        push(1'b0, 9'h0F0, 9'h0A0, 50);
        push(1'b1, 9'h00F, 9'h000, 60);
        push(1'b0, 9'h00F, 9'h003, 70);
        push(1'b0, 9'h1FF, 9'h155, 80);

        idle_to(90);
        push(1'b0, 9'h1FF, 9'h0AA, 82);
        idle_to(100);
        push(1'b0, 9'h0FF, 9'h012, 150);
        push(1'b1, 9'h0F0, 9'h000, 160);
        pin_phase = 1'b0;
        apply_reset();
        idle_to(200);

        rand_drv = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            int         r, n, ws;
            bit         v, op;
            logic [8:0] mk, vl;
            r  = $urandom_range(0, 99);
            op = ($urandom_range(0, 3) == 0);
            mk = ($urandom_range(0, 7) == 0) ? 9'h000 : 9'($urandom);
            vl = 9'($urandom);
            ws = (last_vis > tcyc + 1) ? last_vis : tcyc + 1;
            v  = 1'b1;
            n  = 0;
            if (r < 30) n = ws + int'($urandom_range(0, 5));
            else if (r < 40) begin
                if (have_last && !last_drop && last_vis > tcyc + 1) n = last_n;
                else n = ws + int'($urandom_range(0, 5));
            end else if (r < 43) n = tcyc - int'($urandom_range(1, 300));
            else v = 1'b0;
            tick(v, op, mk, vl, n, acc);
        end
        idle_to(tcyc + 60);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
